// File: rtl/ifetch_unit.sv
// ifetch_unit - instruction-fetch stage.
//
// Owns the architectural PC and fetches one instruction at a time over a
// request/grant/response memory interface. It holds the fetched word for
// decode until decode accepts it, then loads the next PC supplied by the
// next-PC logic.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   npc_in       next PC, sampled only on the decode-accept edge
//   imem_req     fetch request (high while in REQ)
//   imem_addr    fetch address, always equal to pc
//   imem_gnt     memory accepted the request
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   instr        held instruction word
//   instr_valid  instr/pc valid for decode
//   id_ready     decode accepts the held instruction
//   pc           PC of the held instruction
//   imm16        instr[15:0]
//   target       instr[25:0]
//   fetch_err    sticky misaligned-PC error
//
// Build option:
//   ADDR_ERR_EN  when defined, a misaligned npc_in at accept sets fetch_err
//                and halts fetching; when undefined, npc_in is silently
//                word-aligned and fetch_err is tied to 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | first cycle after reset, no request issued
// REQ   | request asserted, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | instruction presented to decode (or halted after fetch_err)

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic [31:0] pc,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign imm16     = instr[15:0];
  assign target    = instr[25:0];

`ifdef ADDR_ERR_EN
  logic err_q;

  assign fetch_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: if (imem_gnt) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Once err_q is set the block stays parked here until reset.
          if (id_ready && !err_q) begin
            pc          <= npc_in;
            instr_valid <= 1'b0;
            if (npc_in[1:0] != 2'b00) err_q <= 1'b1;
            else                      state <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
`else
  // Low PC bits are dropped by the alignment below.
  logic unused_npc_lsb;
  assign unused_npc_lsb = ^npc_in[1:0];

  assign fetch_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: if (imem_gnt) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            pc          <= {npc_in[31:2], 2'b00};
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
`endif

endmodule
